// File: rtl/rca_pipelined_if.sv
// Handshake and data bundle for rca_pipelined.
// The master drives operands and downstream ready. The slave is the adder.
interface rca_pipelined_if #(
  parameter int unsigned WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic             iSub;
  logic             iC;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oS;
  logic             oC;
  logic             oV;

  modport master (
    output iValid, iSub, iC, iA, iB, iReady,
    input  oReady, oValid, oS, oC, oV
  );

  modport slave (
    input  iValid, iSub, iC, iA, iB, iReady,
    output oReady, oValid, oS, oC, oV
  );
endinterface

// File: rtl/rca_pipelined.sv
// Pipelined ripple-carry add/subtract.
// The WIDTH-bit add is split into STAGES chunks of CW bits. Stage k adds chunk k
// and registers its carry for stage k+1. Operands travel alongside the partial
// sum, so the last stage holds a fully aligned result. All stages stall together
// whenever the output is full and downstream is not ready.
module rca_pipelined #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic            iClk,
  input logic            iRst_n,
  rca_pipelined_if.slave bus
);
  localparam int unsigned CW = WIDTH / STAGES;

  logic adv;

  // Per-stage registers. Entry k is the output of stage k.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ov_q;

  // Per-stage inputs and next-state values.
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [CW:0]       chunk;
  logic              msb_cin;
  logic              ov_d;

  // Global advance: the pipeline moves unless the output is stuck.
  assign adv        = ~vld_q[STAGES-1] | bus.iReady;
  assign bus.oReady = adv;

  assign bus.oValid = vld_q[STAGES-1];
  assign bus.oS     = s_q[STAGES-1];
  assign bus.oC     = c_q[STAGES-1];
  assign bus.oV     = ov_q;

  // Route each stage's inputs: stage 0 from the bus, others from the previous stage.
  always_comb begin
    vld_in[0] = bus.iValid;
    a_in[0]   = bus.iA;
    b_in[0]   = bus.iSub ? ~bus.iB : bus.iB;
    s_in[0]   = '0;
    c_in[0]   = bus.iC;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      s_in[k]   = s_q[k-1];
      c_in[k]   = c_q[k-1];
    end
  end

  // Chunk adders: stage k replaces chunk k of the travelling partial sum.
  always_comb begin
    chunk   = '0;
    msb_cin = 1'b0;
    ov_d    = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
            + {{CW{1'b0}}, c_in[k]};
      s_d[k]              = s_in[k];
      s_d[k][k*CW +: CW]  = chunk[CW-1:0];
      c_d[k]              = chunk[CW];
    end
    // Carry into the MSB recovered from the MSB sum bit; overflow = cin ^ cout.
    msb_cin = s_d[STAGES-1][WIDTH-1] ^ a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];
    ov_d    = msb_cin ^ c_d[STAGES-1];
  end

  // Stage registers: shift on advance; data only loads for valid slots so bubbles
  // leave the previous contents (and thus the output data) untouched.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ov_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_in;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (vld_in[STAGES-1]) begin
        ov_q <= ov_d;
      end
    end
  end
endmodule

// File: tb/tb_rca_pipelined.sv
// Scoreboard bench for rca_pipelined: 8-bit/2-stage main instance with directed,
// streaming, reset and backpressure phases, plus 32/4 and 32/1 instances
// streaming random ops with exact latency checks.
module tb_rca_pipelined;
  localparam int unsigned W0 = 8;
  localparam int unsigned S0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    int          t;
  } exp_t;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: integer arithmetic on the operands as unsigned and signed numbers.
  function automatic exp_t model(int unsigned w, logic [31:0] a, logic [31:0] b,
                                 logic sub, logic cin);
    longint lim, ua, ub, us, sa, sb, ss;
    exp_t e;
    lim = longint'(1) << w;
    ua  = longint'(a) & (lim - 1);
    ub  = longint'(b) & (lim - 1);
    if (sub) ub = lim - 1 - ub;
    us  = ua + ub + longint'(cin);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    ss  = sa + sb + longint'(cin);
    e.s = 32'(us % lim);
    e.c = (us >= lim);
    e.v = (ss >= lim / 2) || (ss < -(lim / 2));
    e.t = 0;
    return e;
  endfunction

  function automatic exp_t mk(logic [31:0] s, logic c, logic v);
    exp_t e;
    e.s = s;
    e.c = c;
    e.v = v;
    e.t = 0;
    return e;
  endfunction

  // ---------------- main instance ----------------
  rca_pipelined_if #(.WIDTH(W0)) bus0 ();
  rca_pipelined #(.WIDTH(W0), .STAGES(S0)) u0 (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus0.slave)
  );

  exp_t q0[$];
  logic lat_chk = 1'b0;
  logic strict  = 1'b0;

  // Monitor: pops on every output transfer, checks holds while stalled.
  logic       held = 1'b0;
  logic [7:0] hs;
  logic       hc, hv;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (bus0.oValid && !bus0.iReady) begin
        if (held) begin
          chk("hold_s", bus0.oS, hs);
          chk("hold_c", bus0.oC, hc);
          chk("hold_v", bus0.oV, hv);
        end
        held = 1'b1;
        hs = bus0.oS;
        hc = bus0.oC;
        hv = bus0.oV;
      end else begin
        held = 1'b0;
      end
      if (bus0.oValid && bus0.iReady) begin
        if (q0.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("sum", bus0.oS, e.s[7:0]);
          chk("carry", bus0.oC, e.c);
          chk("ovf", bus0.oV, e.v);
          if (lat_chk) chk("latency", cyc - e.t, S0);
        end
      end
    end
  end

  task automatic send(logic [7:0] a, logic [7:0] b, logic sub, logic cin, exp_t e);
    int guard = 0;
    @(negedge clk);
    bus0.iValid = 1'b1;
    bus0.iA     = a;
    bus0.iB     = b;
    bus0.iSub   = sub;
    bus0.iC     = cin;
    #2;
    if (strict) chk("ready_stream", bus0.oReady, 1);
    while (!bus0.oReady && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (!bus0.oReady) begin
      chk("accept_timeout", 0, 1);
      bus0.iValid = 1'b0;
    end else begin
      e.t = cyc;
      q0.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rand();
    logic [7:0] a, b;
    logic sub, cin;
    a   = 8'($urandom);
    b   = 8'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
    send(a, b, sub, cin, model(W0, {24'b0, a}, {24'b0, b}, sub, cin));
  endtask

  task automatic idle();
    @(negedge clk);
    bus0.iValid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q0.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", q0.size(), 0);
  endtask

  // ---------------- parameter instances: 32/4 and 32/1 ----------------
  logic par_run = 1'b0;
  int   par_pend [2];

  for (genvar g = 0; g < 2; g++) begin : g_par
    localparam int unsigned PW = 32;
    localparam int unsigned PS = (g == 0) ? 4 : 1;

    rca_pipelined_if #(.WIDTH(PW)) bus ();
    rca_pipelined #(.WIDTH(PW), .STAGES(PS)) u (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus.slave)
    );

    exp_t q[$];

    initial begin
      par_pend[g] = 0;
      bus.iValid  = 1'b0;
      bus.iReady  = 1'b1;
      bus.iSub    = 1'b0;
      bus.iC      = 1'b0;
      bus.iA      = '0;
      bus.iB      = '0;
    end

    // Driver: random ops with occasional bubbles; downstream always ready.
    always @(negedge clk) begin
      exp_t e;
      if (par_run && ($urandom_range(3) != 0)) begin
        bus.iValid = 1'b1;
        bus.iA     = $urandom;
        bus.iB     = $urandom;
        bus.iSub   = 1'($urandom);
        bus.iC     = 1'($urandom);
        e   = model(PW, bus.iA, bus.iB, bus.iSub, bus.iC);
        e.t = cyc;
        q.push_back(e);
        par_pend[g]++;
      end else begin
        bus.iValid = 1'b0;
      end
    end

    always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n && bus.oValid) begin
        if (q.size() == 0) begin
          chk("par_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          par_pend[g]--;
          chk("par_sum", bus.oS, e.s);
          chk("par_carry", bus.oC, e.c);
          chk("par_ovf", bus.oV, e.v);
          chk("par_latency", cyc - e.t, PS);
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    bus0.iValid = 1'b0;
    bus0.iReady = 1'b1;
    bus0.iSub   = 1'b0;
    bus0.iC     = 1'b0;
    bus0.iA     = '0;
    bus0.iB     = '0;

    // Reset state
    #3;
    chk("rst_valid", bus0.oValid, 0);
    chk("rst_sum", bus0.oS, 0);
    chk("rst_ready", bus0.oReady, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with two ops in flight: results must be discarded
    bus0.iReady = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0, mk(32'h46, 1'b0, 1'b0));
    send(8'h21, 8'h10, 1'b0, 1'b0, mk(32'h31, 1'b0, 1'b0));
    bus0.iValid = 1'b0;
    #1;
    chk("inflight_valid", bus0.oValid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus0.oValid, 0);
    chk("rst_mid_sum", bus0.oS, 0);
    chk("rst_mid_carry", bus0.oC, 0);
    chk("rst_mid_ovf", bus0.oV, 0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus0.iReady = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("post_rst_valid", bus0.oValid, 0);
    chk("post_rst_ready", bus0.oReady, 1);

    // Directed add/sub corner cases with exact latency
    lat_chk = 1'b1;
    send(8'hFF, 8'h01, 1'b0, 1'b0, mk(32'h00, 1'b1, 1'b0));
    send(8'h7F, 8'h01, 1'b0, 1'b0, mk(32'h80, 1'b0, 1'b1));
    send(8'h05, 8'h07, 1'b1, 1'b1, mk(32'hFE, 1'b0, 1'b0));
    send(8'h80, 8'h01, 1'b1, 1'b1, mk(32'h7F, 1'b1, 1'b1));
    idle();
    drain();

    // Back-to-back random stream
    strict = 1'b1;
    for (int i = 0; i < 256; i++) send_rand();
    strict = 1'b0;
    idle();
    drain();

    // Backpressure while full
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand();
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        bus0.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #2;
          chk("stall_ready", bus0.oReady, 0);
          chk("stall_valid", bus0.oValid, 1);
          @(negedge clk);
        end
        bus0.iReady = 1'b1;
      end
    join
    drain();

    // Other parameterisations
    par_run = 1'b1;
    repeat (300) @(negedge clk);
    par_run = 1'b0;
    repeat (10) @(negedge clk);
    chk("par4_drain", par_pend[0], 0);
    chk("par1_drain", par_pend[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
